// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the PC/ROM side and the issue side of the fetch sequencer.
//   address, instr        : PC value and ROM word into the sequencer
//   vector, offset,
//   jump_enable,
//   jump_address          : PC control out of the sequencer
//   issue_*               : registered issue record to the SIMD datapath
//   halted                : registered HALT flag
// master = sequencer, slave = PC/ROM/datapath side.
interface fetch_sequencer_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8
);
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] instr;
    logic               vector;
    logic [1:0]         offset;
    logic               jump_enable;
    logic [ADDR_W-1:0]  jump_address;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic [1:0]         issue_lane;
    logic               issue_vector;
    logic [ADDR_W-1:0]  issue_pc;
    logic               halted;

    modport master (
        input  address, instr,
        output vector, offset, jump_enable, jump_address,
        output issue_valid, issue_instr, issue_lane, issue_vector, issue_pc, halted
    );

    modport slave (
        output address, instr,
        input  vector, offset, jump_enable, jump_address,
        input  issue_valid, issue_instr, issue_lane, issue_vector, issue_pc, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Drives program_counter from the synchronous ROM output: expands scalar
// instructions into four lane issues while holding the PC, redirects on JMP
// (squashing the wrong-path word), and stops fetch on HALT.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_sequencer_if.master (PC control, issue record, halted)
//
// state   | meaning
// FILL    | first cycle after reset, ROM output not yet valid
// RUN     | decode ROM word, issue vector ops, start scalar/jump/halt
// LANE    | issuing lanes 1..3 of a latched scalar op, PC held until lane 3
// FLUSH   | discard the wrong-path word fetched behind a JMP
// HALT    | fetch stopped until reset
module fetch_sequencer #(
    parameter int          INSTR_W = 32,
    parameter int          ADDR_W  = 8,
    parameter logic [3:0]  OP_JMP  = 4'b1110,
    parameter logic [3:0]  OP_HALT = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_FILL,
        S_RUN,
        S_LANE,
        S_FLUSH,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic [1:0]         lane_cnt;

    logic [3:0]         opcode;
    logic               v_bit;
    logic               is_jmp;
    logic               is_halt;
    logic [ADDR_W-1:0]  prev_pc;

    assign opcode  = bus.instr[INSTR_W-1 -: 4];
    assign v_bit   = bus.instr[INSTR_W-5];
    assign is_jmp  = (opcode == OP_JMP);
    assign is_halt = (opcode == OP_HALT);
    // The ROM word corresponds to the address sampled one edge earlier.
    assign prev_pc = bus.address - ADDR_ONE;

    // PC control is combinational: the PC samples it on the same edge.
    always_comb begin
        bus.vector       = 1'b1;
        bus.offset       = 2'd0;
        bus.jump_enable  = 1'b0;
        bus.jump_address = '0;
        case (state)
            S_RUN: begin
                if (is_jmp) begin
                    bus.jump_enable  = 1'b1;
                    bus.jump_address = bus.instr[ADDR_W-1:0];
                end else if (!is_halt && !v_bit) begin
                    bus.vector = 1'b0;
                end
            end
            S_LANE: begin
                bus.offset = lane_cnt;
                bus.vector = (lane_cnt == 2'd3);
            end
            S_HALT: begin
                bus.vector = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_FILL;
            ir               <= '0;
            ir_pc            <= '0;
            lane_cnt         <= 2'd0;
            bus.issue_valid  <= 1'b0;
            bus.issue_instr  <= '0;
            bus.issue_lane   <= 2'd0;
            bus.issue_vector <= 1'b0;
            bus.issue_pc     <= '0;
            bus.halted       <= 1'b0;
        end else begin
            bus.issue_valid <= 1'b0;
            case (state)
                S_FILL: state <= S_RUN;
                S_RUN: begin
                    if (is_halt) begin
                        state      <= S_HALT;
                        bus.halted <= 1'b1;
                    end else if (is_jmp) begin
                        state <= S_FLUSH;
                    end else begin
                        bus.issue_valid  <= 1'b1;
                        bus.issue_instr  <= bus.instr;
                        bus.issue_lane   <= 2'd0;
                        bus.issue_vector <= v_bit;
                        bus.issue_pc     <= prev_pc;
                        if (!v_bit) begin
                            ir       <= bus.instr;
                            ir_pc    <= prev_pc;
                            lane_cnt <= 2'd1;
                            state    <= S_LANE;
                        end
                    end
                end
                S_LANE: begin
                    bus.issue_valid  <= 1'b1;
                    bus.issue_instr  <= ir;
                    bus.issue_lane   <= lane_cnt;
                    bus.issue_vector <= 1'b0;
                    bus.issue_pc     <= ir_pc;
                    lane_cnt         <= lane_cnt + 2'd1;
                    if (lane_cnt == 2'd3) begin
                        state <= S_RUN;
                    end
                end
                S_FLUSH: state <= S_RUN;
                S_HALT:  state <= S_HALT;
                default: state <= S_FILL;
            endcase
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control-side counterpart of program_counter. It consumes the PC `address` and the instruction word returned by the synchronous instruction ROM, and drives the PC's `vector`, `offset`, `jump_enable` and `jump_address` inputs. It expands scalar instructions into four sequential lane issues and redirects the PC on jumps, squashing the wrong-path fetch. It also stops fetch on HALT and presents registered issue records to the SIMD datapath.

Parameters:
INSTR_W, 32, instruction word width
ADDR_W, 8, PC/address width; must equal the program_counter address width
OP_JMP, 4'b1110, opcode for an unconditional jump; target is instr[ADDR_W-1:0]
OP_HALT, 4'b1111, opcode that stops fetch until reset

Ports:
clk  in  1  system clock, all state on the rising edge
reset  in  1  asynchronous, active-low reset
address  in  ADDR_W  current PC value from program_counter
instr  in  INSTR_W  ROM output; holds the word at the `address` sampled on the previous edge
vector  out  1  to PC: 1 = advance/normal, 0 = hold PC
offset  out  2  to PC: lane index while PC is held; 0 otherwise
jump_enable  out  1  to PC: load jump_address on the next edge
jump_address  out  ADDR_W  to PC: jump target
issue_valid  out  1  registered: issue record valid this cycle
issue_instr  out  INSTR_W  registered: instruction being issued
issue_lane  out  2  registered: lane for a scalar issue; 0 for a vector issue
issue_vector  out  1  registered: 1 = all-lane issue, 0 = single-lane issue
issue_pc  out  ADDR_W  registered: address of the issued instruction
halted  out  1  registered: high once HALT has been decoded

Behaviour:
- Decode fields: opcode = instr[31:28]; V bit = instr[27]. The JMP and HALT opcodes override the V bit.
- The PC-control outputs (vector, offset, jump_enable, jump_address) are combinational from state, instr and lane_cnt. The PC samples them on the same edge.
- State machine states: FILL, RUN, LANE, FLUSH, HALT.
- Internal registers: ir (INSTR_W), ir_pc (ADDR_W), lane_cnt (2 bits).
- Reset (async, low): state=FILL, lane_cnt=0, ir=0, ir_pc=0. All issue_* outputs=0 and halted=0.
- Combinational outputs during reset and in FILL: vector=1, offset=0, jump_enable=0, jump_address=0.
- FILL (1 cycle): instr is not yet valid; nothing is issued. vector=1. Next state: RUN.
- RUN, instruction with V=1: issue next cycle with issue_vector=1, issue_lane=0, issue_pc=address-1 (mod 2^ADDR_W). vector=1. Stay in RUN.
- RUN, instruction with V=0 (scalar): issue lane 0 next cycle and set vector=0, offset=0. Latch ir<=instr, ir_pc<=address-1, lane_cnt<=1. Next state: LANE.
- LANE: issue ir with issue_lane=lane_cnt and issue_pc=ir_pc. Drive offset=lane_cnt and vector=(lane_cnt==3). Increment lane_cnt. When lane_cnt==3, go to RUN.
- Scalar timing: 4 issue cycles with the PC held for 3 of them. Because the PC is held, the ROM output equals the next instruction on return to RUN, so no refetch is needed.
- RUN, JMP: nothing issued. jump_enable=1 and jump_address=instr[ADDR_W-1:0] for exactly one cycle, with vector=1. Next state: FLUSH.
- FLUSH: the instr presented (wrong path, PC+1) is discarded and nothing is issued. vector=1. Next state: RUN, where instr is the word at the target.
- Jump to self (target equals the JMP's own address) is legal and loops with one JMP/FLUSH pair every 2 cycles.
- RUN, HALT: nothing issued. Next state: HALT; halted=1 from the next cycle.
- HALT: vector=0, offset=0, jump_enable=0, issue_valid=0. The state persists until reset.
- issue_valid is 1 only in the cycle after a RUN vector/scalar decode and after each LANE cycle. It is 0 after FILL, JMP, FLUSH and HALT.
- Wrap: issue_pc uses modulo-2^ADDR_W subtraction, so address 0 gives issue_pc 255.
- Reset asserted mid-LANE or mid-FLUSH returns immediately to FILL. No partial issue occurs after release.

Test Plan:
- Reset release with ROM[0..2] = vector ops (V=1) -> FILL for 1 cycle, then issue_valid=1 on consecutive cycles with issue_pc=0,1,2, issue_vector=1, issue_lane=0, vector held 1.
- ROM[0] = scalar op (V=0), ROM[1] = vector op -> four issues of ROM[0] with issue_lane 0,1,2,3 and issue_pc=0. Offset output 0,1,2,3 with vector=0,0,0,1. Then ROM[1] issues with issue_pc=1.
- ROM[3] = JMP with target 0x14 -> jump_enable=1 and jump_address=0x14 for one cycle. No issue for ROM[3] or ROM[4]. The next issue has issue_pc=0x14.
- ROM[5] = HALT -> halted=1 and vector=0 from the next cycle. No further issue_valid for 20 cycles. Asserting reset low clears halted, and the run restarts at issue_pc=0.
- Reset pulsed low during LANE at lane_cnt=2 -> outputs return to reset values at once. After release, the first issue is issue_pc=0, lane 0.
- ROM[255] = vector op, ROM[0] = vector op -> issue_pc 255 followed by issue_pc 0 (PC wrap). The next issue has issue_pc=0; no stale issue_pc appears.
